vitals_tracker: RTL and testbench

- Owns both fighters' health and shield and drives the 4-bit p1/p2 health and shield values consumed by the health/shield bar renderer.
- Converts hit and block events from the combat logic into saturating health/shield updates, with shield regeneration and per-player hit cooldown.
- Runs the round state machine: idle, fight, KO.
- Sits between the fighter/collision logic (upstream) and the VGA bar display (downstream).

---
 rtl/vitals_tracker_pkg.sv | 34 +++
 rtl/vitals_tracker_if.sv | 35 +++
 rtl/vitals_tracker_fighter_vitals.sv | 107 ++++++++++
 rtl/vitals_tracker.sv | 127 ++++++++++++
 tb/tb_vitals_tracker.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vitals_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vitals_tracker_pkg
//  Description : Shared round-state encodings, winner codes, default bar
//                maxima and a saturating-subtract helper for the vitals
//                tracker and the bar renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vitals_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        KO    = 2'd2
    } state_t;

    typedef logic [1:0] winner_t;

    localparam winner_t WIN_NONE = 2'd0;
    localparam winner_t WIN_P1   = 2'd1;
    localparam winner_t WIN_P2   = 2'd2;
    localparam winner_t WIN_DRAW = 2'd3;

    // The bar renderer sizes its bars from these as well.
    localparam int DEF_MAX_HEALTH = 15;
    localparam int DEF_MAX_SHIELD = 15;

    // Compare first so a 4-bit value never wraps below zero.
    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vitals_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module      : vitals_tracker_if
//  Description : Combat-event inputs and vitals/round outputs of the
//                vitals tracker, bundled for the fighter logic and the bars.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vitals_tracker_if
    import vitals_tracker_pkg::*;
    ;
    logic       round_start;
    logic       p1_hit;
    logic       p2_hit;
    logic       p1_blocking;
    logic       p2_blocking;
    logic [3:0] p1_health;
    logic [3:0] p1_shield;
    logic [3:0] p2_health;
    logic [3:0] p2_shield;
    logic       game_over;
    winner_t    winner;

    // Combat logic side: raises events, observes vitals.
    modport master (
        output round_start, p1_hit, p2_hit, p1_blocking, p2_blocking,
        input  p1_health, p1_shield, p2_health, p2_shield, game_over, winner
    );

    // Tracker side.
    modport slave (
        input  round_start, p1_hit, p2_hit, p1_blocking, p2_blocking,
        output p1_health, p1_shield, p2_health, p2_shield, game_over, winner
    );
endinterface
`default_nettype wire

// File: rtl/vitals_tracker_fighter_vitals.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_vitals
//  Description : One player's health and shield with hit cooldown and
//                shield regeneration. Active only while enabled; reload
//                restores full bars and clears both counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fighter_vitals
    import vitals_tracker_pkg::*;
#(
    parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
    parameter int MAX_SHIELD   = DEF_MAX_SHIELD,
    parameter int DAMAGE       = 2,
    parameter int SHIELD_COST  = 3,
    parameter int REGEN_TICKS  = 25000000,
    parameter int HIT_COOLDOWN = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       reload,
    input  logic       hit,
    input  logic       blocking,
    output logic [3:0] health,
    output logic [3:0] shield
);

    localparam logic [3:0]       MAX_H      = 4'(MAX_HEALTH);
    localparam logic [3:0]       MAX_S      = 4'(MAX_SHIELD);
    localparam logic [3:0]       DMG        = 4'(DAMAGE);
    localparam logic [3:0]       COST       = 4'(SHIELD_COST);
    localparam logic [CNT_W-1:0] REGEN_LAST = CNT_W'(REGEN_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(HIT_COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       health_q, health_d;
    logic [3:0]       shield_q, shield_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic [CNT_W-1:0] regen_q, regen_d;
    logic             hit_reg;
    logic             regen_wrap;

    // Next-state for vitals and counters; a registered hit beats a regen wrap.
    always_comb begin
        health_d   = health_q;
        shield_d   = shield_q;
        cool_d     = cool_q;
        regen_d    = regen_q;
        hit_reg    = 1'b0;
        regen_wrap = 1'b0;
        if (reload) begin
            health_d = MAX_H;
            shield_d = MAX_S;
            cool_d   = '0;
            regen_d  = '0;
        end else if (enable) begin
            hit_reg = hit && (cool_q == '0);

            if (hit_reg) begin
                cool_d = COOL_LOAD;
            end else if (cool_q != '0) begin
                cool_d = cool_q - CNT_ONE;
            end

            if (blocking || (shield_q >= MAX_S)) begin
                regen_d = '0;
            end else if (regen_q == REGEN_LAST) begin
                regen_d    = '0;
                regen_wrap = 1'b1;
            end else begin
                regen_d = regen_q + CNT_ONE;
            end

            if (hit_reg) begin
                if (blocking && (shield_q != 4'd0)) begin
                    shield_d = sat_sub(shield_q, COST);
                end else begin
                    health_d = sat_sub(health_q, DMG);
                end
            end else if (regen_wrap && (shield_q < MAX_S)) begin
                shield_d = shield_q + 4'd1;
            end
        end
    end

    // State register; full bars out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            health_q <= MAX_H;
            shield_q <= MAX_S;
            cool_q   <= '0;
            regen_q  <= '0;
        end else begin
            health_q <= health_d;
            shield_q <= shield_d;
            cool_q   <= cool_d;
            regen_q  <= regen_d;
        end
    end

    assign health = health_q;
    assign shield = shield_q;

endmodule
`default_nettype wire

// File: rtl/vitals_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : vitals_tracker
//  Description : Round FSM (idle / fight / KO) and winner decision around two
//                per-player vitals blocks feeding the health/shield bars.
//  Revision    : 1.0 - initial release
// ============================================================================
module vitals_tracker
    import vitals_tracker_pkg::*;
#(
    parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
    parameter int MAX_SHIELD   = DEF_MAX_SHIELD,
    parameter int DAMAGE       = 2,
    parameter int SHIELD_COST  = 3,
    parameter int REGEN_TICKS  = 25000000,
    parameter int HIT_COOLDOWN = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic            clk,
    input  logic            reset_n,
    vitals_tracker_if.slave bus
);

    state_t  state_q, state_d;
    logic    game_over_q, game_over_d;
    winner_t winner_q, winner_d;
    logic    fight_en;

    assign fight_en = (state_q == FIGHT);

    fighter_vitals #(
        .MAX_HEALTH  (MAX_HEALTH),
        .MAX_SHIELD  (MAX_SHIELD),
        .DAMAGE      (DAMAGE),
        .SHIELD_COST (SHIELD_COST),
        .REGEN_TICKS (REGEN_TICKS),
        .HIT_COOLDOWN(HIT_COOLDOWN),
        .CNT_W       (CNT_W)
    ) u_p1 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (fight_en),
        .reload  (bus.round_start),
        .hit     (bus.p1_hit),
        .blocking(bus.p1_blocking),
        .health  (bus.p1_health),
        .shield  (bus.p1_shield)
    );

    fighter_vitals #(
        .MAX_HEALTH  (MAX_HEALTH),
        .MAX_SHIELD  (MAX_SHIELD),
        .DAMAGE      (DAMAGE),
        .SHIELD_COST (SHIELD_COST),
        .REGEN_TICKS (REGEN_TICKS),
        .HIT_COOLDOWN(HIT_COOLDOWN),
        .CNT_W       (CNT_W)
    ) u_p2 (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (fight_en),
        .reload  (bus.round_start),
        .hit     (bus.p2_hit),
        .blocking(bus.p2_blocking),
        .health  (bus.p2_health),
        .shield  (bus.p2_shield)
    );

    // Round transitions; round_start always wins, KO is judged on registered health.
    always_comb begin
        state_d     = state_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        case (state_q)
            IDLE: begin
                if (bus.round_start) begin
                    state_d = FIGHT;
                end
            end
            FIGHT: begin
                if (bus.round_start) begin
                    state_d     = FIGHT;
                    game_over_d = 1'b0;
                    winner_d    = WIN_NONE;
                end else if ((bus.p1_health == 4'd0) || (bus.p2_health == 4'd0)) begin
                    state_d     = KO;
                    game_over_d = 1'b1;
                    if ((bus.p1_health == 4'd0) && (bus.p2_health == 4'd0)) begin
                        winner_d = WIN_DRAW;
                    end else if (bus.p2_health == 4'd0) begin
                        winner_d = WIN_P1;
                    end else begin
                        winner_d = WIN_P2;
                    end
                end
            end
            KO: begin
                if (bus.round_start) begin
                    state_d     = FIGHT;
                    game_over_d = 1'b0;
                    winner_d    = WIN_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Round state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_vitals_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vitals_tracker
//  Description : Directed self-checking bench for vitals_tracker with
//                REGEN_TICKS=8 and HIT_COOLDOWN=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vitals_tracker;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    vitals_tracker_if vif ();

    vitals_tracker #(
        .REGEN_TICKS (8),
        .HIT_COOLDOWN(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle hit pulse on the selected players.
    task automatic pulse_hits(input logic h1, input logic h2);
        vif.p1_hit = h1;
        vif.p2_hit = h2;
        tick(1);
        vif.p1_hit = 1'b0;
        vif.p2_hit = 1'b0;
    endtask

    task automatic check_full(input string tag);
        check({tag, "_p1h"}, int'(vif.p1_health), 15);
        check({tag, "_p1s"}, int'(vif.p1_shield), 15);
        check({tag, "_p2h"}, int'(vif.p2_health), 15);
        check({tag, "_p2s"}, int'(vif.p2_shield), 15);
        check({tag, "_go"},  int'(vif.game_over), 0);
        check({tag, "_win"}, int'(vif.winner),    0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n         = 1'b0;
        vif.round_start = 1'b0;
        vif.p1_hit      = 1'b0;
        vif.p2_hit      = 1'b0;
        vif.p1_blocking = 1'b0;
        vif.p2_blocking = 1'b0;

        // Reset values and IDLE ignoring hits
        tick(2);
        check_full("reset");
        check("reset_state", int'(dut.state_q), 0);
        reset_n = 1'b1;
        tick(1);
        pulse_hits(1'b0, 1'b1);
        check("idle_ignore_p2h", int'(vif.p2_health), 15);

        // Round start
        vif.round_start = 1'b1;
        tick(1);
        vif.round_start = 1'b0;
        check_full("start");
        check("start_state", int'(dut.state_q), 1);

        // Single unblocked hit on p2
        pulse_hits(1'b0, 1'b1);
        check("p2_hit_h", int'(vif.p2_health), 13);
        check("p2_hit_s", int'(vif.p2_shield), 15);
        tick(3);

        // Held blocked hit on p1: registrations at edges 1, 5, 9 of 12
        vif.p1_blocking = 1'b1;
        vif.p1_hit      = 1'b1;
        tick(1);
        check("hold_s1", int'(vif.p1_shield), 12);
        tick(4);
        check("hold_s2", int'(vif.p1_shield), 9);
        tick(4);
        check("hold_s3", int'(vif.p1_shield), 6);
        tick(3);
        vif.p1_hit = 1'b0;
        check("hold_s_end", int'(vif.p1_shield), 6);
        check("hold_h", int'(vif.p1_health), 15);

        // Walk p1 shield down to 1: 6 -> 3, regen to 4, 4 -> 1
        pulse_hits(1'b1, 1'b0);
        check("blk_s3", int'(vif.p1_shield), 3);
        tick(3);
        vif.p1_blocking = 1'b0;
        tick(8);
        check("regen_s4", int'(vif.p1_shield), 4);
        vif.p1_blocking = 1'b1;
        pulse_hits(1'b1, 1'b0);
        check("blk_s1", int'(vif.p1_shield), 1);
        tick(3);

        // Shield 1 -> 0 without underflow, then an empty shield lets damage through
        pulse_hits(1'b1, 1'b0);
        check("blk_s0", int'(vif.p1_shield), 0);
        check("blk_s0_h", int'(vif.p1_health), 15);
        tick(3);
        pulse_hits(1'b1, 1'b0);
        check("empty_h", int'(vif.p1_health), 13);
        check("empty_s", int'(vif.p1_shield), 0);
        tick(3);

        // Regen after releasing block
        vif.p1_blocking = 1'b0;
        tick(8);
        check("regen_1", int'(vif.p1_shield), 1);
        tick(8);
        check("regen_2", int'(vif.p1_shield), 2);

        // p2 health 13 -> 1 in six hits, then KO
        for (int i = 0; i < 6; i++) begin
            pulse_hits(1'b0, 1'b1);
            tick(3);
        end
        check("p2_at_1", int'(vif.p2_health), 1);
        pulse_hits(1'b0, 1'b1);
        check("p2_zero", int'(vif.p2_health), 0);
        check("ko_not_yet", int'(vif.game_over), 0);
        tick(1);
        check("ko_go", int'(vif.game_over), 1);
        check("ko_win", int'(vif.winner), 1);
        check("ko_state", int'(dut.state_q), 2);

        // Frozen in KO: p1 shield regen stopped at 5 (26 regen edges after reaching 2)
        vif.p1_hit = 1'b1;
        vif.p2_hit = 1'b1;
        tick(4);
        vif.p1_hit = 1'b0;
        vif.p2_hit = 1'b0;
        check("frz_p1h", int'(vif.p1_health), 13);
        check("frz_p1s", int'(vif.p1_shield), 5);
        check("frz_p2h", int'(vif.p2_health), 0);
        check("frz_go",  int'(vif.game_over), 1);
        check("frz_win", int'(vif.winner), 1);

        // Restart from KO
        vif.round_start = 1'b1;
        tick(1);
        vif.round_start = 1'b0;
        check_full("restart");

        // round_start has priority over a hit in the same cycle
        vif.round_start = 1'b1;
        vif.p1_hit      = 1'b1;
        tick(1);
        vif.round_start = 1'b0;
        vif.p1_hit      = 1'b0;
        check("prio_p1h", int'(vif.p1_health), 15);

        // Simultaneous hits down to 1 each (odd max), then a draw
        for (int i = 0; i < 7; i++) begin
            pulse_hits(1'b1, 1'b1);
            tick(3);
        end
        check("sim_p1h1", int'(vif.p1_health), 1);
        check("sim_p2h1", int'(vif.p2_health), 1);
        pulse_hits(1'b1, 1'b1);
        check("sim_p1h0", int'(vif.p1_health), 0);
        check("sim_p2h0", int'(vif.p2_health), 0);
        tick(1);
        check("draw_go",  int'(vif.game_over), 1);
        check("draw_win", int'(vif.winner), 3);

        // Asynchronous reset mid-round
        vif.round_start = 1'b1;
        tick(1);
        vif.round_start = 1'b0;
        pulse_hits(1'b1, 1'b0);
        check("pre_rst_p1h", int'(vif.p1_health), 13);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_p1h",  int'(vif.p1_health), 15);
        check("arst_go",   int'(vif.game_over), 0);
        check("arst_state", int'(dut.state_q), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
